cgra_run_ctrl: RTL and testbench

- Parametrised run controller and BRAM channel interface for the CGRA top level.
- Generalises the fixed two-channel load/store bridge to `NUM_CH` channels.
- Adds a start/launch/done handshake FSM with a busy-rise timeout and error flag.
- Adds a run-cycle counter.
- Sits between the PE array (torus) and the host-shared data BRAMs. Software drives `Computation_Start` and observes `Computation_Done`.

---
 rtl/cgra_run_ctrl_if.sv | 43 ++++
 rtl/cgra_run_ctrl.sv | 157 +++++++++++++++
 tb/tb_cgra_run_ctrl.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cgra_run_ctrl_if.sv
// Handshake and BRAM channel bundle for cgra_run_ctrl.
// master: host, PE array and BRAM side; slave: the run controller.
interface cgra_run_ctrl_if #(
  parameter int NUM_CH     = 2,
  parameter int SYS_DWIDTH = 32,
  parameter int BYTE_LEN   = 4,
  parameter int AWIDTH     = 16
);
  logic                           Computation_Start;
  logic                           Computation_Done;
  logic                           Run_Error;
  logic [31:0]                    Cycle_Count;
  logic                           PE_Array_Start;
  logic                           PE_Array_Busy;
  logic [NUM_CH-1:0]              Cgra_En;
  logic [NUM_CH*BYTE_LEN-1:0]     Cgra_Wen;
  logic [NUM_CH*AWIDTH-1:0]       Cgra_Addr;
  logic [NUM_CH*SYS_DWIDTH-1:0]   Cgra_Data_Store;
  logic [NUM_CH*SYS_DWIDTH-1:0]   Cgra_Data_Load;
  logic [NUM_CH-1:0]              Bram_Clk;
  logic [NUM_CH-1:0]              Bram_Rst;
  logic [NUM_CH-1:0]              Bram_En;
  logic [NUM_CH*BYTE_LEN-1:0]     Bram_Wen;
  logic [NUM_CH*SYS_DWIDTH-1:0]   Bram_Addr;
  logic [NUM_CH*SYS_DWIDTH-1:0]   Bram_Data_To_Bram;
  logic [NUM_CH*SYS_DWIDTH-1:0]   Bram_Data_From_Bram;

  modport master (
    output Computation_Start, PE_Array_Busy, Cgra_En, Cgra_Wen, Cgra_Addr,
           Cgra_Data_Store, Bram_Data_From_Bram,
    input  Computation_Done, Run_Error, Cycle_Count, PE_Array_Start,
           Cgra_Data_Load, Bram_Clk, Bram_Rst, Bram_En, Bram_Wen, Bram_Addr,
           Bram_Data_To_Bram
  );

  modport slave (
    input  Computation_Start, PE_Array_Busy, Cgra_En, Cgra_Wen, Cgra_Addr,
           Cgra_Data_Store, Bram_Data_From_Bram,
    output Computation_Done, Run_Error, Cycle_Count, PE_Array_Start,
           Cgra_Data_Load, Bram_Clk, Bram_Rst, Bram_En, Bram_Wen, Bram_Addr,
           Bram_Data_To_Bram
  );
endinterface

// File: rtl/cgra_run_ctrl.sv
// CGRA run controller: start/launch/done FSM with busy timeout plus NUM_CH gated BRAM channels.
// Define CGRA_CYCLE_COUNTER_EN to build the saturating run-cycle counter on Cycle_Count.
module cgra_run_ctrl #(
  parameter int NUM_CH     = 2,
  parameter int SYS_DWIDTH = 32,
  parameter int BYTE_LEN   = 4,
  parameter int AWIDTH     = 16,
  parameter int TIMEOUT    = 255
) (
  input  logic           Clk,
  input  logic           Resetn,
  cgra_run_ctrl_if.slave bus
);
  localparam int            BSHIFT  = $clog2(BYTE_LEN);
  localparam int            TW      = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT);
  localparam int            DW      = NUM_CH * SYS_DWIDTH;
  localparam int            WW      = NUM_CH * BYTE_LEN;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LAUNCH    = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_RUN       = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  state_t            r_state;
  logic              r_start_prev;
  logic              r_pe_start;
  logic              r_done;
  logic              r_error;
  logic [TW-1:0]     r_tmo;
  logic [NUM_CH-1:0] r_bram_en;
  logic [WW-1:0]     r_bram_wen;
  logic [DW-1:0]     r_bram_addr;
  logic [DW-1:0]     r_bram_wdata;
  logic [DW-1:0]     r_load;

  logic              w_start_rise;
  logic              w_gate;
  logic [DW-1:0]     w_byte_addr;

  assign w_start_rise = bus.Computation_Start & ~r_start_prev;
  assign w_gate       = (r_state == S_WAIT_BUSY) || (r_state == S_RUN);

  // Run sequencing; the previous-Start register resets high so a level held through reset cannot launch.
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      r_state      <= S_IDLE;
      r_start_prev <= 1'b1;
      r_pe_start   <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_tmo        <= {TW{1'b0}};
    end else begin
      r_start_prev <= bus.Computation_Start;
      r_pe_start   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start_rise) begin
            r_state    <= S_LAUNCH;
            r_pe_start <= 1'b1;
            r_error    <= 1'b0;
          end
        end
        S_LAUNCH: begin
          r_state <= S_WAIT_BUSY;
          r_tmo   <= {TW{1'b0}};
        end
        S_WAIT_BUSY: begin
          if (bus.PE_Array_Busy) begin
            r_state <= S_RUN;
          end else if (r_tmo == TMO_MAX) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_error <= 1'b1;
          end else begin
            r_tmo <= r_tmo + TW'(1);
          end
        end
        S_RUN: begin
          if (!bus.PE_Array_Busy) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          if (!bus.Computation_Start) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

`ifdef CGRA_CYCLE_COUNTER_EN
  logic [31:0] r_cycle_count;

  // Counts WAIT_BUSY and RUN cycles, saturating, cleared on launch.
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      r_cycle_count <= 32'd0;
    end else if ((r_state == S_IDLE) && w_start_rise) begin
      r_cycle_count <= 32'd0;
    end else if (w_gate && (r_cycle_count != 32'hFFFF_FFFF)) begin
      r_cycle_count <= r_cycle_count + 32'd1;
    end
  end

  assign bus.Cycle_Count = r_cycle_count;
`else
  assign bus.Cycle_Count = 32'd0;
`endif

  // Word address to byte address, per channel.
  always_comb begin
    w_byte_addr = {DW{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      w_byte_addr[i*SYS_DWIDTH +: SYS_DWIDTH] =
        SYS_DWIDTH'(bus.Cgra_Addr[i*AWIDTH +: AWIDTH]) << BSHIFT;
    end
  end

  // Channel request registers; enables are masked outside WAIT_BUSY/RUN so the host owns the BRAM.
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      r_bram_en    <= {NUM_CH{1'b0}};
      r_bram_wen   <= {WW{1'b0}};
      r_bram_addr  <= {DW{1'b0}};
      r_bram_wdata <= {DW{1'b0}};
      r_load       <= {DW{1'b0}};
    end else begin
      r_bram_en    <= w_gate ? bus.Cgra_En  : {NUM_CH{1'b0}};
      r_bram_wen   <= w_gate ? bus.Cgra_Wen : {WW{1'b0}};
      r_bram_addr  <= w_byte_addr;
      r_bram_wdata <= bus.Cgra_Data_Store;
      r_load       <= bus.Bram_Data_From_Bram;
    end
  end

  assign bus.Computation_Done  = r_done;
  assign bus.Run_Error         = r_error;
  assign bus.PE_Array_Start    = r_pe_start;
  assign bus.Bram_Clk          = {NUM_CH{Clk}};
  assign bus.Bram_Rst          = {NUM_CH{~Resetn}};
  assign bus.Bram_En           = r_bram_en;
  assign bus.Bram_Wen          = r_bram_wen;
  assign bus.Bram_Addr         = r_bram_addr;
  assign bus.Bram_Data_To_Bram = r_bram_wdata;
  assign bus.Cgra_Data_Load    = r_load;
endmodule

// File: tb/tb_cgra_run_ctrl.sv
// Randomized bench for cgra_run_ctrl: each run is scheduled as cycle numbers, and the
// expected outputs follow arithmetically from that schedule; a BRAM model closes the data loop.
module tb_cgra_run_ctrl;
  localparam int NUM_CH = 4;
  localparam int SD     = 32;
  localparam int BL     = 4;
  localparam int AW     = 16;
  localparam int TMO    = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  cgra_run_ctrl_if #(.NUM_CH(NUM_CH), .SYS_DWIDTH(SD), .BYTE_LEN(BL), .AWIDTH(AW)) bus ();

  cgra_run_ctrl #(.NUM_CH(NUM_CH), .SYS_DWIDTH(SD), .BYTE_LEN(BL), .AWIDTH(AW), .TIMEOUT(TMO)) dut (
    .Clk    (clk),
    .Resetn (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // run schedule: launch request in cycle r_S, Done rises in r_D, last Done cycle r_E
  bit run_valid = 1'b0;
  int r_S = 0, r_D = 0, r_E = 0;
  bit r_to = 1'b0;
  bit hold_err = 1'b0;
  int hold_cnt = 0;
  bit rnd_ch = 1'b1;
  int last_s, last_fd, pulse_cnt, done_cycles;

  // BRAM model, one-cycle read latency, read-before-write
  logic [SD-1:0]        mem [NUM_CH][64] = '{default: '0};
  logic [NUM_CH*SD-1:0] bram_rd = '0;
  assign bus.Bram_Data_From_Bram = bram_rd;

  always @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (bus.Bram_En[i]) begin
        bram_rd[i*SD +: SD] <= mem[i][bus.Bram_Addr[i*SD+2 +: 6]];
        for (int j = 0; j < BL; j++)
          if (bus.Bram_Wen[i*BL+j])
            mem[i][bus.Bram_Addr[i*SD+2 +: 6]][j*8 +: 8] <= bus.Bram_Data_To_Bram[i*SD+j*8 +: 8];
      end
    end
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // history of the previous cycle's inputs for the one-cycle channel path
  logic [NUM_CH-1:0]    h_en;
  logic [NUM_CH*BL-1:0] h_wen;
  logic [NUM_CH*AW-1:0] h_addr;
  logic [NUM_CH*SD-1:0] h_store, h_from;
  bit h_gate = 1'b0;
  bit prev_ok = 1'b0;

  always @(negedge clk) begin
    logic [31:0] cnt_e;
    logic [NUM_CH*SD-1:0] addr_e;
    if (!rst_n) begin
      chk("rst_done", bus.Computation_Done, 0);
      chk("rst_pe_start", bus.PE_Array_Start, 0);
      chk("rst_err", bus.Run_Error, 0);
      chk("rst_cnt", bus.Cycle_Count, 0);
      chk("rst_bram_en", bus.Bram_En, 0);
      chk("rst_bram_wen", bus.Bram_Wen, 0);
      chk("rst_bram_addr", bus.Bram_Addr, 0);
      chk("rst_load", bus.Cgra_Data_Load, 0);
      chk("rst_bram_rst", bus.Bram_Rst, 4'hF);
      prev_ok = 1'b0;
    end else begin
      cnt_e = 32'd0;
      if (run_valid && cyc > r_S) begin
        chk("run_error", bus.Run_Error, r_to && cyc >= r_D);
        if (cyc >= r_S + 2) cnt_e = (cyc <= r_D) ? 32'(cyc - r_S - 2) : 32'(r_D - r_S - 2);
      end else begin
        chk("run_error", bus.Run_Error, hold_err);
        cnt_e = 32'(hold_cnt);
      end
`ifndef CGRA_CYCLE_COUNTER_EN
      cnt_e = 32'd0;
`endif
      chk("cycle_count", bus.Cycle_Count, cnt_e);
      chk("pe_start", bus.PE_Array_Start, run_valid && cyc == r_S + 1);
      chk("done", bus.Computation_Done, run_valid && cyc >= r_D && cyc <= r_E);
      chk("bram_rst", bus.Bram_Rst, 0);
      if (prev_ok) begin
        for (int i = 0; i < NUM_CH; i++)
          addr_e[i*SD +: SD] = 32'(h_addr[i*AW +: AW]) * 32'd4;
        chk("bram_en", bus.Bram_En, h_gate ? h_en : '0);
        chk("bram_wen", bus.Bram_Wen, h_gate ? h_wen : '0);
        chk("bram_addr", bus.Bram_Addr, addr_e);
        chk("bram_wdata", bus.Bram_Data_To_Bram, h_store);
        chk("load", bus.Cgra_Data_Load, h_from);
      end
      prev_ok = 1'b1;
    end
    h_en    = bus.Cgra_En;
    h_wen   = bus.Cgra_Wen;
    h_addr  = bus.Cgra_Addr;
    h_store = bus.Cgra_Data_Store;
    h_from  = bus.Bram_Data_From_Bram;
    h_gate  = run_valid && cyc >= r_S + 2 && cyc <= r_D - 1;
  end

  task automatic drive_rand_ch();
    logic [AW-1:0] a;
    for (int i = 0; i < NUM_CH; i++) begin
      bus.Cgra_En[i]              = 1'($urandom_range(0, 1));
      bus.Cgra_Wen[i*BL +: BL]    = BL'($urandom);
      a = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 63));
      bus.Cgra_Addr[i*AW +: AW]   = a;
      bus.Cgra_Data_Store[i*SD +: SD] = $urandom;
    end
  endtask

  task automatic zero_ch();
    bus.Cgra_En = '0;
    bus.Cgra_Wen = '0;
    bus.Cgra_Addr = '0;
    bus.Cgra_Data_Store = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_ch) drive_rand_ch();
  endtask

  task automatic close_run();
    if (run_valid) begin
      hold_err = r_to;
      hold_cnt = r_D - r_S - 2;
    end
  endtask

  // One run: Busy rises w cycles into WAIT_BUSY and stays b cycles (w > TMO: never),
  // Start held h cycles, then gap idle cycles.
  task automatic run_one(input int w, input int b, input int h, input int gap, input bit dir);
    int s, rel;
    close_run();
    s = cyc;
    r_to = (w > TMO);
    r_S  = s;
    r_D  = r_to ? s + 3 + TMO : s + 3 + w + b;
    r_E  = (s + h > r_D) ? s + h : r_D;
    run_valid = 1'b1;
    last_s = s; last_fd = -1; pulse_cnt = 0; done_cycles = 0;
    bus.Computation_Start = 1'b1;
    bus.PE_Array_Busy = 1'b0;
    while (cyc <= r_E) begin
      tick();
      if (bus.PE_Array_Start) pulse_cnt++;
      if (bus.Computation_Done) done_cycles++;
      if (bus.Computation_Done && last_fd < 0) last_fd = cyc;
      bus.Computation_Start = (cyc < s + h);
      bus.PE_Array_Busy = !r_to && cyc >= s + 2 + w && cyc <= s + 1 + w + b;
      if (dir) begin
        rel = cyc - s;
        if (rel == 5) begin
          chk("wr_bram_en", bus.Bram_En, 4'b0100);
          chk("wr_bram_addr", bus.Bram_Addr[2*SD +: SD], 32'h0000_0040);
          chk("wr_bram_wen", bus.Bram_Wen[2*BL +: BL], 4'hF);
          chk("wr_bram_data", bus.Bram_Data_To_Bram[2*SD +: SD], 32'hDEAD_BEEF);
        end
        if (rel == 8) chk("rd_load", bus.Cgra_Data_Load[2*SD +: SD], 32'hDEAD_BEEF);
        zero_ch();
        if (rel == 4 || rel == 5) begin
          bus.Cgra_En[2] = 1'b1;
          bus.Cgra_Addr[2*AW +: AW] = 16'h0010;
        end
        if (rel == 4) begin
          bus.Cgra_Wen[2*BL +: BL] = 4'hF;
          bus.Cgra_Data_Store[2*SD +: SD] = 32'hDEAD_BEEF;
        end
      end
    end
    repeat (gap) tick();
  endtask

  initial begin
    bit seen;
    int s;
    bus.Computation_Start = 1'b1;
    bus.PE_Array_Busy = 1'b0;
    zero_ch();
    repeat (3) tick();
    chk("bram_clk_high", bus.Bram_Clk, 4'hF);
    #6 chk("bram_clk_low", bus.Bram_Clk, 4'h0);
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin tick(); seen |= bus.PE_Array_Start; end
    chk("held_start_no_launch", seen, 0);
    bus.Computation_Start = 1'b0;
    repeat (2) tick();

    // idle requests must not reach the BRAM
    rnd_ch = 1'b0;
    bus.Cgra_En = '1;
    bus.Cgra_Wen = '1;
    repeat (2) tick();
    chk("idle_bram_en", bus.Bram_En, 0);
    chk("idle_bram_wen", bus.Bram_Wen, 0);

    run_one(0, 10, 20, 2, 1'b1);
    chk("pulse_width", pulse_cnt, 1);
    chk("done_after_busy_fall", last_fd - (last_s + 12), 1);
    chk("done_hold_cycles", done_cycles, 8);
    chk("done_low_after_start_low", bus.Computation_Done, 0);
`ifdef CGRA_CYCLE_COUNTER_EN
    chk("run_cycle_count", bus.Cycle_Count, 32'd11);
`else
    chk("run_cycle_count", bus.Cycle_Count, 32'd0);
`endif

    rnd_ch = 1'b1;
    run_one(TMO + 5, 1, 3, 2, 1'b0);
    chk("timeout_latency", last_fd - (last_s + 2), 9);
    chk("timeout_error", bus.Run_Error, 1);
`ifdef CGRA_CYCLE_COUNTER_EN
    chk("timeout_cycle_count", bus.Cycle_Count, 32'd9);
`else
    chk("timeout_cycle_count", bus.Cycle_Count, 32'd0);
`endif

    for (int k = 0; k < 25; k++)
      run_one($urandom_range(0, TMO + 3), $urandom_range(1, 15), $urandom_range(1, 25),
              $urandom_range(0, 3), 1'b0);

    // reset in the middle of RUN
    rnd_ch = 1'b0;
    zero_ch();
    bus.Cgra_En = '1;
    close_run();
    s = cyc;
    r_S = s; r_D = s + 54; r_E = s + 54; r_to = 1'b0;
    run_valid = 1'b1;
    bus.Computation_Start = 1'b1;
    while (cyc < s + 6) begin
      tick();
      bus.PE_Array_Busy = (cyc >= s + 3);
    end
    chk("run_bram_en", bus.Bram_En, 4'hF);
    #2 rst_n = 1'b0;
    #1;
    chk("async_bram_en", bus.Bram_En, 0);
    chk("async_done", bus.Computation_Done, 0);
    chk("async_pe_start", bus.PE_Array_Start, 0);
    chk("async_bram_rst", bus.Bram_Rst, 4'hF);
    run_valid = 1'b0;
    hold_err = 1'b0;
    hold_cnt = 0;
    bus.PE_Array_Busy = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (4) tick();
    bus.Computation_Start = 1'b0;
    repeat (2) tick();
    rnd_ch = 1'b1;
    run_one(2, 6, 4, 2, 1'b0);
    chk("post_reset_pulse", pulse_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
